// File: rtl/pipe_dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   WORD_W  : data word width
//   state_e : responder FSM encoding (also driven on the debug state port)
package pipe_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage : pipe_pkg

// File: rtl/pipe_dmem_responder_if.sv
// MEM-stage load/store bus between the CPU (master) and the data memory
// responder (slave).
//   mreq   : request valid, held high by the master until it sees mready
//   mwe    : 1 = store, 0 = load; stable while mreq is high
//   maddr  : byte address; stable while mreq is high
//   mwdata : store data; stable while mreq is high
//   mrdata : load data, valid with mready, held until the next load completes
//   mready : one-cycle completion pulse
//   mbusy  : combinational mreq & ~mready, feeds the CPU stall logic
//   merr   : fault flag, meaningful only while mready is high
// Handshake: a request is taken when the responder is idle and mreq is high;
// it completes on the single cycle mready is high, after which the master may
// drop mreq or present the next request.
interface pipe_dmem_responder_if;
    import pipe_pkg::*;

    logic              mreq;
    logic              mwe;
    logic [31:0]       maddr;
    logic [WORD_W-1:0] mwdata;
    logic [WORD_W-1:0] mrdata;
    logic              mready;
    logic              mbusy;
    logic              merr;

    modport master (
        output mreq, mwe, maddr, mwdata,
        input  mrdata, mready, mbusy, merr
    );

    modport slave (
        input  mreq, mwe, maddr, mwdata,
        output mrdata, mready, mbusy, merr
    );

endinterface : pipe_dmem_responder_if

// File: rtl/pipe_dmem_responder_array.sv
// DEPTH x WORD_W word storage for the data memory responder.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (read register only; storage is not reset)
//   we_i    : synchronous write enable
//   re_i    : read strobe; loads the registered read port
//   clr_i   : with re_i, loads zero instead of the addressed word (faulting load)
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, holds between reads
module dmem_array
    import pipe_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= clr_i ? '0 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/pipe_dmem_responder.sv
// Memory-side responder for the pipelined CPU's MEM-stage load/store bus.
// Takes one word request at a time, waits WAIT_STATES cycles, performs the
// access on the internal array and returns a one-cycle mready pulse.
//   clock       : sole clock, rising edge
//   reset       : asynchronous active-high reset
//   bus         : slave side of pipe_dmem_responder_if
//   dbg_state_o : current FSM state, for observation only
// Optional feature: define DMEM_ERR_EN to flag misaligned or out-of-range
// addresses (merr with mready, no write, zero load data). Without it the
// low two address bits and the bits above the index are ignored (aliasing)
// and merr is tied low.
module pipe_dmem_responder
    import pipe_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    pipe_dmem_responder_if.slave  bus,
    output state_e                dbg_state_o
);

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              mready_q, mready_d;
    logic              merr_q, merr_d;

    logic              arr_we;
    logic              arr_re;
    logic              req_fault;

`ifdef DMEM_ERR_EN
    assign req_fault = (bus.maddr[1:0] != 2'b00) || (bus.maddr[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign req_fault        = 1'b0;
    assign unused_addr_bits = ^{bus.maddr[31:AW+2], bus.maddr[1:0]};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            mready_q <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            mready_q <= mready_d;
            merr_q   <= merr_d;
        end
    end

    // The captured request is the only thing the access uses; bus inputs are
    // looked at again only once the FSM is back in IDLE.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        mready_d = 1'b0;
        merr_d   = 1'b0;
        arr_we   = 1'b0;
        arr_re   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mreq) begin
                    we_d    = bus.mwe;
                    idx_d   = bus.maddr[AW+1:2];
                    wdata_d = bus.mwdata;
                    err_d   = req_fault;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == WS_L) begin
                    state_d = S_ACCESS;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                // A faulting request keeps normal timing but suppresses the
                // write and returns zero for a load.
                arr_we   = we_q & ~err_q;
                arr_re   = ~we_q;
                mready_d = 1'b1;
                merr_d   = err_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .clr_i   (err_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (bus.mrdata)
    );

    assign bus.mready  = mready_q;
    assign bus.mbusy   = bus.mreq & ~mready_q;
    assign bus.merr    = merr_q;
    assign dbg_state_o = state_q;

endmodule : pipe_dmem_responder

// File: tb/tb_pipe_dmem_responder.sv
// Bench for pipe_dmem_responder. Two instances: dut_a with one wait state,
// dut_b with none. A shared driver is steered to one of them by cur.
module tb_pipe_dmem_responder;
    import pipe_pkg::*;

    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    pipe_dmem_responder_if bus_a ();
    pipe_dmem_responder_if bus_b ();
    state_e state_a, state_b;

    pipe_dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) dut_a (
        .clock       (clk),
        .reset       (rst),
        .bus         (bus_a.slave),
        .dbg_state_o (state_a)
    );

    pipe_dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
        .clock       (clk),
        .reset       (rst),
        .bus         (bus_b.slave),
        .dbg_state_o (state_b)
    );

    logic        cur;
    logic        drv_mreq;
    logic        drv_mwe;
    logic [31:0] drv_maddr;
    logic [31:0] drv_mwdata;

    assign bus_a.mreq   = drv_mreq & ~cur;
    assign bus_a.mwe    = drv_mwe;
    assign bus_a.maddr  = drv_maddr;
    assign bus_a.mwdata = drv_mwdata;
    assign bus_b.mreq   = drv_mreq & cur;
    assign bus_b.mwe    = drv_mwe;
    assign bus_b.maddr  = drv_maddr;
    assign bus_b.mwdata = drv_mwdata;

    logic        obs_mready, obs_mbusy, obs_merr;
    logic [31:0] obs_mrdata;
    assign obs_mready = cur ? bus_b.mready : bus_a.mready;
    assign obs_mbusy  = cur ? bus_b.mbusy  : bus_a.mbusy;
    assign obs_merr   = cur ? bus_b.merr   : bus_a.merr;
    assign obs_mrdata = cur ? bus_b.mrdata : bus_a.mrdata;

    // ---------------- checking ----------------
    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [int];
    logic [31:0] last_rd [2];

    function automatic bit is_fault(input logic [31:0] addr);
`ifdef DMEM_ERR_EN
        return (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int key_of(input logic sel, input logic [31:0] addr);
        return (int'(sel) << 16) | int'(addr[9:2]);
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];

    always @(negedge clk) begin
        if (obs_mready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_mready", {obs_merr, obs_mrdata}, 33'h0);
            end else begin
                chk("resp", {obs_merr, obs_mrdata}, exp_q.pop_front());
            end
        end
    end

    // Compute and queue the expected response for one request.
    task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bit          err;
        int          k;
        logic [31:0] rd;
        err = is_fault(addr);
        k   = key_of(cur, addr);
        if (we) begin
            if (!err) mem_m[k] = data;
            rd = last_rd[cur];
        end else begin
            rd = err ? 32'h0 : (mem_m.exists(k) ? mem_m[k] : 32'hxxxx_xxxx);
            last_rd[cur] = rd;
        end
        exp_q.push_back({err, rd});
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input bit drop);
        int n;
        bit got;
        int ws;
        ws = cur ? 0 : 1;
        push_exp(we, addr, data);
        drv_mreq   = 1'b1;
        drv_mwe    = we;
        drv_maddr  = addr;
        drv_mwdata = data;
        #1;
        chk("busy_idle", {32'h0, obs_mbusy}, 33'h1);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (obs_mready) begin
                got = 1'b1;
                if (!drop) chk("busy_at_ready", {32'h0, obs_mbusy}, 33'h0);
            end else if (!drop) begin
                chk("busy_wait", {32'h0, obs_mbusy}, 33'h1);
            end
            if (drop && n == 1) begin
                drv_mreq   = 1'b0;
                drv_maddr  = 32'h20;
                drv_mwdata = 32'h0;
            end
        end
        if (!got) begin
            chk("timeout", 33'(n), 33'h0);
            exp_q.delete();
        end else begin
            chk("latency", 33'(n), 33'(2 + ws));
        end
        drv_mreq = 1'b0;
        @(negedge clk);
        chk("pulse_end", {32'h0, obs_mready}, 33'h0);
    endtask

    // Capture a store, then reset during its wait cycle.
    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] data);
        drv_mreq   = 1'b1;
        drv_mwe    = 1'b1;
        drv_maddr  = addr;
        drv_mwdata = data;
        @(negedge clk);
        rst      = 1'b1;
        drv_mreq = 1'b0;
        #1;
        chk("rst_mready", {32'h0, obs_mready}, 33'h0);
        chk("rst_mrdata", {1'b0, obs_mrdata}, 33'h0);
        chk("rst_merr", {32'h0, obs_merr}, 33'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_ready", {32'h0, obs_mready}, 33'h0);
        end
    endtask

    // Stores with mreq held high throughout; responses must be 3 cycles apart.
    task automatic back_to_back();
        int n;
        int t_prev;
        push_exp(1'b1, 32'h0, 32'h1);
        drv_mreq   = 1'b1;
        drv_mwe    = 1'b1;
        drv_maddr  = 32'h0;
        drv_mwdata = 32'h1;
        t_prev     = cyc;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!obs_mready && n < 40);
            if (!obs_mready) begin
                chk("b2b_timeout", 33'(n), 33'h0);
                exp_q.delete();
                break;
            end
            if (i != 0) chk("b2b_period", 33'(cyc - t_prev), 33'd3);
            t_prev = cyc;
            if (i < 3) begin
                drv_maddr  = 32'(4 * (i + 1));
                drv_mwdata = 32'(i + 2);
                push_exp(1'b1, drv_maddr, drv_mwdata);
            end
        end
        drv_mreq = 1'b0;
        @(negedge clk);
        chk("b2b_pulse_end", {32'h0, obs_mready}, 33'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        cur        = 1'b0;
        rst        = 1'b1;
        drv_mreq   = 1'b0;
        drv_mwe    = 1'b0;
        drv_maddr  = 32'h0;
        drv_mwdata = 32'h0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            chk("reset_out", {obs_merr, obs_mrdata}, 33'h0);
            chk("reset_ready", {31'h0, obs_mready, obs_mbusy}, 33'h0);
        end
        cur = 1'b0;
        @(negedge clk);

        // store then load on the one-wait-state instance
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);

        // random stores and loads
        for (int i = 0; i < 8; i++) do_req(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0);
        for (int i = 0; i < 6; i++) do_req(1'b0, 32'h40 + 32'(4 * $urandom_range(0, 7)), 32'h0, 1'b0);

        // request inputs changed after capture
        do_req(1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0);
        do_req(1'b1, 32'h10, 32'h55, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);

        // reset in the middle of a store
        do_req(1'b1, 32'h14, 32'h1111_1111, 1'b0);
        reset_mid_store(32'h14, 32'h77);
        do_req(1'b0, 32'h14, 32'h0, 1'b0);

        // zero-wait-state instance: back-to-back stores, then reloads
        cur = 1'b1;
        @(negedge clk);
        back_to_back();
        do_req(1'b0, 32'hC, 32'h0, 1'b0);
        do_req(1'b0, 32'h0, 32'h0, 1'b0);

        // fault / aliasing addresses
        cur = 1'b0;
        @(negedge clk);
        do_req(1'b1, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_req(1'b1, 32'h4, 32'h1234_5678, 1'b0);
        do_req(1'b0, 32'h3, 32'h0, 1'b0);
        do_req(1'b0, 32'(DEPTH * 4), 32'h0, 1'b0);
        do_req(1'b1, 32'h6, 32'h0000_0BAD, 1'b0);
        do_req(1'b0, 32'h4, 32'h0, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 33'(exp_q.size()), 33'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_pipe_dmem_responder
